// File: rtl/reg_bank_sequencer.sv
// Sequences one register micro-op (read, write or read-modify-write) against the R0-R7 bank.
// Latency: accept to rsp_valid is 2 edges (read-only/write-only) or 3 edges (RMW); one command in flight.
// Backpressure: cmd_ready only in IDLE; DONE holds the response indefinitely until rsp_ready.
module reg_bank_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic [REG_ADDR_WIDTH-1:0] cmd_reg,
    input  logic [DATA_WIDTH-1:0]     cmd_acc,
    input  logic [DATA_WIDTH-1:0]     cmd_imm,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_result,
    output logic                      rsp_carry,
    output logic                      rsp_jump,
    output logic                      bank_write,
    output logic                      bank_read,
    output logic [REG_ADDR_WIDTH-1:0] bank_in_select,
    output logic [REG_ADDR_WIDTH-1:0] bank_out_select,
    output logic [DATA_WIDTH-1:0]     bank_in_data,
    input  logic [DATA_WIDTH-1:0]     bank_out_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [2:0] OP_MOV_RA = 3'd0;
    localparam logic [2:0] OP_MOV_AR = 3'd1;
    localparam logic [2:0] OP_MOV_RI = 3'd2;
    localparam logic [2:0] OP_INC    = 3'd3;
    localparam logic [2:0] OP_DEC    = 3'd4;
    localparam logic [2:0] OP_XCH    = 3'd5;
    localparam logic [2:0] OP_DJNZ   = 3'd6;
    localparam logic [2:0] OP_ADD    = 3'd7;

    state_t                    state_q, state_d;
    logic [2:0]                op_q;
    logic [REG_ADDR_WIDTH-1:0] reg_q;
    logic [DATA_WIDTH-1:0]     acc_q, imm_q, r_q;
    logic [DATA_WIDTH-1:0]     wdata, result, r_inc, r_dec;
    logic [DATA_WIDTH:0]       sum;
    logic                      in_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            reg_q   <= '0;
            acc_q   <= '0;
            imm_q   <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cmd_valid) begin
                op_q  <= cmd_op;
                reg_q <= cmd_reg;
                acc_q <= cmd_acc;
                imm_q <= cmd_imm;
            end
            if (state_q == READ) begin
                r_q <= bank_out_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = (cmd_op == OP_MOV_AR || cmd_op == OP_MOV_RI) ? WRITE : READ;
                end
            end
            READ:    state_d = (op_q == OP_MOV_RA || op_q == OP_ADD) ? DONE : WRITE;
            WRITE:   state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign r_inc = r_q + DATA_WIDTH'(1);
    assign r_dec = r_q - DATA_WIDTH'(1);
    assign sum   = {1'b0, acc_q} + {1'b0, r_q};

    always_comb begin
        wdata = '0;
        case (op_q)
            OP_MOV_AR, OP_XCH: wdata = acc_q;
            OP_MOV_RI:         wdata = imm_q;
            OP_INC:            wdata = r_inc;
            OP_DEC, OP_DJNZ:   wdata = r_dec;
            default:           wdata = '0;
        endcase
    end

    // MOV_RA and XCH both hand back the pre-op register value.
    always_comb begin
        result = wdata;
        case (op_q)
            OP_MOV_RA, OP_XCH: result = r_q;
            OP_ADD:            result = sum[DATA_WIDTH-1:0];
            default:           result = wdata;
        endcase
    end

    assign in_done         = (state_q == DONE);
    assign cmd_ready       = (state_q == IDLE);
    assign bank_read       = (state_q == READ);
    assign bank_write      = (state_q == WRITE);
    assign bank_in_select  = (state_q != IDLE) ? reg_q : '0;
    assign bank_out_select = (state_q != IDLE) ? reg_q : '0;
    assign bank_in_data    = bank_write ? wdata : '0;
    assign rsp_valid       = in_done;
    assign rsp_result      = in_done ? result : '0;
    assign rsp_carry       = in_done && (op_q == OP_ADD) && sum[DATA_WIDTH];
    assign rsp_jump        = in_done && (op_q == OP_DJNZ) && (r_dec != '0);

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Bench for reg_bank_sequencer: models the R0-R7 bank and checks responses against an arithmetic reference.
module tb_reg_bank_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [2:0] cmd_reg = '0;
    logic [7:0] cmd_acc = '0;
    logic [7:0] cmd_imm = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_result;
    logic       rsp_carry, rsp_jump;
    logic       bank_write, bank_read;
    logic [2:0] bank_in_select, bank_out_select;
    logic [7:0] bank_in_data;
    wire  [7:0] bank_out_data;

    logic [7:0] mem [8];
    int wr_total = 0, rd_total = 0, both_total = 0;
    logic [2:0] last_wsel = '0;
    logic [7:0] last_wdata = '0;

    int compared = 0, mismatched = 0;
    int exp_mem [8];

    always #5 clock = ~clock;

    reg_bank_sequencer dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_reg(cmd_reg),
        .cmd_acc(cmd_acc), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_jump(rsp_jump),
        .bank_write(bank_write), .bank_read(bank_read),
        .bank_in_select(bank_in_select), .bank_out_select(bank_out_select),
        .bank_in_data(bank_in_data), .bank_out_data(bank_out_data)
    );

    assign bank_out_data = bank_read ? mem[bank_out_select] : 8'bz;

    // Register bank: clears under reset, writes at the closing edge of a write pulse.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else begin
            if (bank_write) begin
                mem[bank_in_select] <= bank_in_data;
                wr_total   <= wr_total + 1;
                last_wsel  <= bank_in_select;
                last_wdata <= bank_in_data;
            end
            if (bank_read) rd_total <= rd_total + 1;
            if (bank_read && bank_write) both_total <= both_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_zero"}, {rsp_valid, rsp_carry, rsp_jump, bank_write, bank_read,
              bank_in_select, bank_out_select, bank_in_data, rsp_result}, 32'd0);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    task automatic do_cmd(input int op, input int r, input int acc, input int imm, input int hold);
        int R, sum, exp_wd, exp_res, exp_carry, exp_jump, exp_lat, exp_rd, lat, w0, r0;
        bit exp_wr;
        logic [7:0] held;
        R = exp_mem[r];
        sum = acc + R;
        exp_wr = 1; exp_wd = 0; exp_carry = 0; exp_jump = 0; exp_lat = 3; exp_rd = 1;
        case (op)
            0: begin exp_wr = 0; exp_res = R; exp_lat = 2; end
            1: begin exp_wd = acc; exp_res = acc; exp_lat = 2; exp_rd = 0; end
            2: begin exp_wd = imm; exp_res = imm; exp_lat = 2; exp_rd = 0; end
            3: begin exp_wd = (R + 1) % 256; exp_res = exp_wd; end
            4: begin exp_wd = (R + 255) % 256; exp_res = exp_wd; end
            5: begin exp_wd = acc; exp_res = R; end
            6: begin exp_wd = (R + 255) % 256; exp_res = exp_wd; exp_jump = (exp_wd != 0); end
            default: begin exp_wr = 0; exp_res = sum % 256; exp_carry = sum / 256; exp_lat = 2; end
        endcase

        @(negedge clock);
        check("ready_before", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op[2:0]; cmd_reg = r[2:0]; cmd_acc = acc[7:0]; cmd_imm = imm[7:0];
        w0 = wr_total; r0 = rd_total;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 8) begin
            @(negedge clock);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("result", rsp_result, exp_res);
        check("carry", rsp_carry, exp_carry);
        check("jump", rsp_jump, exp_jump);
        check("write_pulses", wr_total - w0, exp_wr ? 1 : 0);
        check("read_pulses", rd_total - r0, exp_rd);
        if (exp_wr) begin
            check("write_select", last_wsel, r);
            check("write_data", last_wdata, exp_wd);
        end

        held = rsp_result;
        w0 = wr_total; r0 = rd_total;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            @(negedge clock);
            check("hold_valid", rsp_valid, 1);
            check("hold_result", rsp_result, held);
            check("hold_ready", cmd_ready, 0);
            check("hold_bank_quiet", (wr_total - w0) + (rd_total - r0), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("rsp_dropped", rsp_valid, 0);
        check("ready_after", cmd_ready, 1);
        if (exp_wr) exp_mem[r] = exp_wd;
        check("bank_content", mem[r[2:0]], exp_mem[r]);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) exp_mem[i] = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_idle_outputs("reset");

        do_cmd(2, 3, 8'h00, 8'h5A, 0);
        do_cmd(0, 3, 8'h00, 8'h00, 0);

        do_cmd(2, 0, 8'h00, 8'hFF, 0);
        do_cmd(3, 0, 8'h00, 8'h00, 0);
        do_cmd(2, 1, 8'h00, 8'h00, 0);
        do_cmd(4, 1, 8'h00, 8'h00, 0);

        do_cmd(2, 2, 8'h00, 8'h01, 0);
        do_cmd(6, 2, 8'h00, 8'h00, 0);
        do_cmd(6, 2, 8'h00, 8'h00, 0);

        do_cmd(2, 4, 8'h00, 8'h11, 0);
        do_cmd(5, 4, 8'h22, 8'h00, 0);
        do_cmd(2, 5, 8'h00, 8'h20, 0);
        do_cmd(7, 5, 8'hF0, 8'h00, 0);

        do_cmd(1, 7, 8'h3C, 8'h00, 5);
        do_cmd(0, 7, 8'h00, 8'h00, 0);

        // Reset landing on the WRITE cycle of INC R6 must abandon the write.
        do_cmd(2, 6, 8'h00, 8'h40, 0);
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_reg = 3'd6;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        check("rst_read_phase", bank_read, 1);
        @(negedge clock);
        check("rst_write_phase", bank_write, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) exp_mem[i] = 0;
        check_idle_outputs("mid_write_reset");
        check("r6_not_updated", mem[6], 8'h00);

        for (int n = 0; n < 60; n++) begin
            do_cmd($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255),
                   $urandom_range(0, 255), $urandom_range(0, 3));
        end

        check("read_write_exclusive", both_total, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
